pipeline_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage core: arbitrates per-stage stall requests into the 6-bit stall vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It sequences exception flushes. When an exception is raised, it freezes the pipe, drains outstanding AXI-Lite bus transactions, then issues a one-cycle flush with the redirect PC. It also keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_ctrl.sv | 113 +++++++++++
 tb/tb_pipeline_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall arbitration and exception drain/flush sequencing for the 5-stage core
module pipeline_ctrl #(
    parameter int DRAIN_TIMEOUT = 256,
    parameter int TO_W          = 9,
    parameter int PERF_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              excp_valid,
    input  logic [31:0]       excp_target_pc,
    input  logic              ibus_busy,
    input  logic              dbus_busy,
    output logic [5:0]        stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              drain_timeout,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [TO_W-1:0]   DRAIN_LAST = TO_W'(DRAIN_TIMEOUT - 1);
    localparam logic [PERF_W-1:0] PERF_MAX   = '1;

    state_t          state;
    logic [TO_W-1:0] drain_cnt;
    logic            bus_busy;

    assign bus_busy = ibus_busy | dbus_busy;

    // Oldest stalled stage wins; it freezes itself and everything younger.
    always_comb begin
        stall = 6'b000000;
        case (state)
            ST_RUN: begin
                if (excp_valid)        stall = 6'b111111;
                else if (stallreq_mem) stall = 6'b011111;
                else if (stallreq_ex)  stall = 6'b001111;
                else if (stallreq_id)  stall = 6'b000111;
                else if (stallreq_if)  stall = 6'b000011;
                else                   stall = 6'b000000;
            end
            ST_DRAIN: stall = 6'b111111;
            ST_FLUSH: stall = 6'b000000;
            default:  stall = 6'b000000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            flush         <= 1'b0;
            new_pc        <= 32'h0;
            drain_timeout <= 1'b0;
            drain_cnt     <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    flush <= 1'b0;
                    if (excp_valid) begin
                        new_pc <= excp_target_pc;
                        if (bus_busy) begin
                            state <= ST_DRAIN;
                        end else begin
                            state <= ST_FLUSH;
                            flush <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Later exceptions are ignored here so the first redirect PC survives.
                    if (!bus_busy) begin
                        state <= ST_FLUSH;
                        flush <= 1'b1;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        state         <= ST_FLUSH;
                        flush         <= 1'b1;
                        drain_timeout <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + TO_W'(1);
                    end
                end
                ST_FLUSH: begin
                    state     <= ST_RUN;
                    flush     <= 1'b0;
                    drain_cnt <= '0;
                end
                default: begin
                    state     <= ST_RUN;
                    flush     <= 1'b0;
                    drain_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
        end else if (stall[0] && perf_stall_cnt != PERF_MAX) begin
            perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        excp_valid;
    logic [31:0] excp_target_pc;
    logic        ibus_busy, dbus_busy;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        drain_timeout;
    logic [3:0]  perf_stall_cnt;

    int total = 0;
    int bad   = 0;

    pipeline_ctrl #(
        .DRAIN_TIMEOUT(8),
        .TO_W(4),
        .PERF_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stallreq_if(stallreq_if),
        .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex),
        .stallreq_mem(stallreq_mem),
        .excp_valid(excp_valid),
        .excp_target_pc(excp_target_pc),
        .ibus_busy(ibus_busy),
        .dbus_busy(dbus_busy),
        .stall(stall),
        .flush(flush),
        .new_pc(new_pc),
        .drain_timeout(drain_timeout),
        .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs then change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = 4'b0;
        excp_valid = 1'b0;
        excp_target_pc = 32'h0;
        ibus_busy = 1'b0;
        dbus_busy = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_stall", 32'(stall), 32'h00);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_new_pc", new_pc, 32'h0);
        check("rst_timeout", 32'(drain_timeout), 32'h0);
        check("rst_perf", 32'(perf_stall_cnt), 32'h0);

        // Priority, all within one cycle
        stallreq_if = 1'b1; stallreq_id = 1'b1; #1;
        check("prio_if_id", 32'(stall), 32'h07);
        stallreq_mem = 1'b1; #1;
        check("prio_mem", 32'(stall), 32'h1F);
        {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = 4'b0; #1;
        check("prio_none", 32'(stall), 32'h00);
        stallreq_ex = 1'b1; stallreq_if = 1'b1; #1;
        check("prio_ex", 32'(stall), 32'h0F);
        stallreq_ex = 1'b0; #1;
        check("prio_if", 32'(stall), 32'h03);
        stallreq_if = 1'b0; #1;

        // Idle flush
        step();
        excp_valid = 1'b1; excp_target_pc = 32'hBFC00380; stallreq_id = 1'b1; #1;
        check("idle_excp_stall", 32'(stall), 32'h3F);
        step();
        excp_valid = 1'b0; stallreq_id = 1'b0; #1;
        check("idle_flush", 32'(flush), 32'h1);
        check("idle_new_pc", new_pc, 32'hBFC00380);
        check("idle_flush_stall", 32'(stall), 32'h00);
        step();
        check("idle_flush_gone", 32'(flush), 32'h0);

        // Drain with dbus busy for 5 cycles; second exception ignored
        excp_valid = 1'b1; dbus_busy = 1'b1; #1;
        check("drain_c0_stall", 32'(stall), 32'h3F);
        for (int c = 1; c <= 5; c++) begin
            step();
            excp_valid = (c == 2);
            excp_target_pc = (c == 2) ? 32'h0 : 32'hBFC00380;
            if (c == 5) dbus_busy = 1'b0;
            #1;
            check($sformatf("drain_c%0d_stall", c), 32'(stall), 32'h3F);
            check($sformatf("drain_c%0d_flush", c), 32'(flush), 32'h0);
        end
        step();
        excp_valid = 1'b0; #1;
        check("drain_flush", 32'(flush), 32'h1);
        check("drain_new_pc", new_pc, 32'hBFC00380);
        check("drain_flush_stall", 32'(stall), 32'h00);
        step();
        check("drain_flush_gone", 32'(flush), 32'h0);
        check("drain_no_timeout", 32'(drain_timeout), 32'h0);

        // Timeout with ibus stuck busy: flush 9 cycles after the exception
        excp_valid = 1'b1; excp_target_pc = 32'h8000_0180; ibus_busy = 1'b1; #1;
        for (int c = 1; c <= 8; c++) begin
            step();
            excp_valid = 1'b0; #1;
            check($sformatf("to_c%0d_flush", c), 32'(flush), 32'h0);
        end
        step();
        check("to_flush", 32'(flush), 32'h1);
        check("to_new_pc", new_pc, 32'h8000_0180);
        check("to_sticky", 32'(drain_timeout), 32'h1);
        ibus_busy = 1'b0;
        step();
        step();
        check("to_sticky_later", 32'(drain_timeout), 32'h1);
        check("to_flush_gone", 32'(flush), 32'h0);

        // Reset mid-drain
        excp_valid = 1'b1; excp_target_pc = 32'h1234_5678; dbus_busy = 1'b1;
        step();
        excp_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; dbus_busy = 1'b0; #1;
        check("rstd_flush", 32'(flush), 32'h0);
        check("rstd_stall", 32'(stall), 32'h00);
        check("rstd_perf", 32'(perf_stall_cnt), 32'h0);
        check("rstd_timeout", 32'(drain_timeout), 32'h0);
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("rstd_noflush%0d", c), 32'(flush), 32'h0);
        end

        // Perf counter saturation
        stallreq_if = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 5) check("perf_5", 32'(perf_stall_cnt), 32'h5);
        end
        check("perf_sat", 32'(perf_stall_cnt), 32'hF);
        stallreq_if = 1'b0;
        step();
        check("perf_hold", 32'(perf_stall_cnt), 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
